mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-ported memory between the instruction-fetch requester (control unit, IR load path) and the load/store requester (data path).
- Grants one access at a time, drives the memory address/data/write strobe, counts the fixed memory latency, captures read data and pulses a per-requester done.
- Sits between the control unit / datapath and the memory block, in place of the direct memory-selector mux.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from address presentation to valid mem_rdata; legal range 1..7
- STARVE_MAX, 4, consecutive load/store grants tolerated while fetch waits (used only with MEMARB_FAIR_EN)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted (1-cycle pulse)
- if_done  out  1  fetch complete, rdata valid (1-cycle pulse)
- ls_req  in  1  load/store request (level)
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_gnt  out  1  load/store granted (1-cycle pulse)
- ls_done  out  1  load/store complete (1-cycle pulse)
- rdata  out  DATA_W  captured read data, shared by both requesters
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_w  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: clk, with reset synchronous and active-high. All outputs are registered.
- Reset: state=IDLE; all gnt, done, mem_w and busy = 0; mem_addr, mem_wdata and rdata = 0; latency counter and starvation counter = 0.
- Reset asserted mid-access: the access is aborted. No done is issued, and mem_w is low from the next cycle.
- States: IDLE, ACCESS, DONE.
- IDLE, arbitration:
  - Requests are sampled only in IDLE.
  - Fixed priority: ls_req beats if_req.
  - On the edge sampling a request: register the winner's address, data and we into mem_addr/mem_wdata; load counter=MEM_LAT; go to ACCESS.
- ACCESS:
  - Winner's gnt is high for the first ACCESS cycle only.
  - mem_w is high for the first ACCESS cycle only, and only for a store.
  - Counter decrements each cycle. On the edge where counter==1: capture mem_rdata into rdata (loads and fetches only) and go to DONE.
  - mem_addr and mem_wdata are held stable through ACCESS.
- DONE: owner's done is high for 1 cycle; always return to IDLE, giving one bubble cycle between accesses.
- Latency: request sampled at edge E0 -> gnt in cycle E0+1 -> done in cycle E0+MEM_LAT+1.
- rdata: holds its value until the next load/fetch capture; a store leaves rdata unchanged.
- Requester rules:
  - Hold req and operands stable until gnt is seen.
  - Deassert req on the edge that samples gnt; req outside IDLE is ignored.
  - Dropping req before gnt withdraws the request; no access occurs.
- Simultaneous if_req and ls_req in IDLE: ls wins; fetch stays pending and is granted at the next IDLE if still requested.
- MEM_LAT=1: ACCESS lasts exactly 1 cycle; gnt, mem_w and the capture all happen in that cycle.
- Only one gnt and one done may be high in any cycle; if and ls signals are never high together.

Optional Feature:
- Macro: MEMARB_FAIR_EN
- Defined:
  - A 3-bit starvation counter increments on each ls grant made while if_req is high.
  - When the counter reaches STARVE_MAX and if_req is high in IDLE, fetch wins over ls.
  - The counter clears on a fetch grant, or in any IDLE cycle with if_req low.
- Undefined: pure fixed priority (ls > if); the counter logic is absent.

Test Plan:
1. Reset, then if_req with if_addr=0x00000010, mem_rdata=0xDEADBEEF, MEM_LAT=2 -> if_gnt at cycle 1; if_done at cycle 3 with rdata=0xDEADBEEF; mem_w stays 0; busy high for cycles 1-3.
2. Store: ls_req, ls_we=1, ls_addr=0x40, ls_wdata=0x12345678 -> mem_w high only in the first ACCESS cycle with mem_addr=0x40 and mem_wdata=0x12345678; ls_done at cycle 3; rdata unchanged.
3. if_req and ls_req raised in the same IDLE cycle -> ls_gnt first, then if_gnt granted 4 cycles later (after DONE plus the bubble); never both gnt high at once.
4. Reset asserted on the second ACCESS cycle of a load -> next cycle state is IDLE with all outputs 0; no ls_done is ever issued.
5. MEM_LAT=1 build, back-to-back fetches at 0x0 then 0x4 -> each completes gnt-to-done in 2 cycles, with one IDLE bubble between accesses.
6. MEMARB_FAIR_EN, STARVE_MAX=4, ls_req and if_req held continuously -> 4 ls grants, then an if grant, then ls resumes.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Define MEMARB_FAIR_EN to let a starved fetch overtake load/store after STARVE_MAX grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_w,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
    $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must lie in 1..7");
  end

  state_t     state;
  logic [2:0] lat_cnt;
  logic       owner_ls;
  logic       op_we;
  logic       fetch_first;
  logic       ls_win;
  logic       if_win;

  // Arbitration terms are only consumed while the FSM sits in IDLE.
  assign ls_win = ls_req && !fetch_first;
  assign if_win = if_req && !ls_win;

`ifdef MEMARB_FAIR_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt;

  assign fetch_first = if_req && (starve_cnt >= STARVE_LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!if_req || if_win) begin
        starve_cnt <= '0;
      end else if (ls_win && starve_cnt != 3'd7) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  assign fetch_first = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_cnt   <= '0;
      owner_ls  <= 1'b0;
      op_we     <= 1'b0;
      if_gnt    <= 1'b0;
      if_done   <= 1'b0;
      ls_gnt    <= 1'b0;
      ls_done   <= 1'b0;
      mem_w     <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_gnt  <= 1'b0;
      ls_gnt  <= 1'b0;
      if_done <= 1'b0;
      ls_done <= 1'b0;
      mem_w   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ls_win) begin
            owner_ls  <= 1'b1;
            op_we     <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_w     <= ls_we;
            ls_gnt    <= 1'b1;
            lat_cnt   <= LAT_INIT;
            busy      <= 1'b1;
            state     <= S_ACCESS;
          end else if (if_win) begin
            owner_ls  <= 1'b0;
            op_we     <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            if_gnt    <= 1'b1;
            lat_cnt   <= LAT_INIT;
            busy      <= 1'b1;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            if (!op_we) begin
              rdata <= mem_rdata;
            end
            if (owner_ls) begin
              ls_done <= 1'b1;
            end else begin
              if_done <= 1'b1;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
